// File: rtl/multi_gate_lot_counter.sv
// Car park occupancy counter: per-gate a/b beam sequence decoders feeding a shared saturating count.
// Optional input debounce filter is enabled by defining LOT_DEBOUNCE_EN.
module multi_gate_lot_counter #(
  parameter int NUM_GATES       = 2,
  parameter int CAPACITY        = 15,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] a,
  input  logic [NUM_GATES-1:0] b,
  output logic [CNT_W-1:0]     no_cars,
  output logic                 full,
  output logic                 empty,
  output logic [NUM_GATES-1:0] entered,
  output logic [NUM_GATES-1:0] exited,
  output logic [NUM_GATES-1:0] seq_err,
  output logic                 overflow,
  output logic                 underflow
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    ERR  = 3'd7
  } state_t;

  localparam int TW = CNT_W + $clog2(NUM_GATES) + 2;

  logic [NUM_GATES-1:0] a_src, b_src;

`ifdef LOT_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NS = 2 * NUM_GATES;

  logic [NS-1:0] raw;
  logic [NS-1:0] filt_q, filt_d;
  logic [DW-1:0] dcnt_q [NS];
  logic [DW-1:0] dcnt_d [NS];

  assign raw = {b, a};

  // The counter only advances while raw disagrees with the filtered value; any agreement restarts it.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NS; i++) begin
      dcnt_d[i] = '0;
      if (raw[i] != filt_q[i]) begin
        if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          filt_d[i] = raw[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= '0;
      for (int i = 0; i < NS; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      filt_q <= filt_d;
      for (int i = 0; i < NS; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  assign a_src = filt_q[NUM_GATES-1:0];
  assign b_src = filt_q[NS-1:NUM_GATES];
`else
  assign a_src = a;
  assign b_src = b;
`endif

  logic [NUM_GATES-1:0] sa_q, sb_q;
  state_t               state_q [NUM_GATES];
  state_t               state_d [NUM_GATES];
  logic [NUM_GATES-1:0] ent_commit, ext_commit, err_enter;

  // Per-gate sequence decoder; every state holds on its own code.
  always_comb begin
    logic [1:0] s_code;
    s_code     = 2'b00;
    ent_commit = '0;
    ext_commit = '0;
    err_enter  = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      s_code     = {sa_q[g], sb_q[g]};
      state_d[g] = state_q[g];
      case (state_q[g])
        IDLE: begin
          case (s_code)
            2'b10:   state_d[g] = E1;
            2'b01:   state_d[g] = X1;
            2'b11:   state_d[g] = ERR;
            default: state_d[g] = IDLE;
          endcase
        end
        E1: begin
          case (s_code)
            2'b11:   state_d[g] = E2;
            2'b00:   state_d[g] = IDLE;
            2'b01:   state_d[g] = ERR;
            default: state_d[g] = E1;
          endcase
        end
        E2: begin
          case (s_code)
            2'b01:   state_d[g] = E3;
            2'b10:   state_d[g] = E1;
            2'b00:   state_d[g] = ERR;
            default: state_d[g] = E2;
          endcase
        end
        E3: begin
          case (s_code)
            2'b00: begin
              state_d[g]    = IDLE;
              ent_commit[g] = 1'b1;
            end
            2'b11:   state_d[g] = E2;
            2'b10:   state_d[g] = ERR;
            default: state_d[g] = E3;
          endcase
        end
        X1: begin
          case (s_code)
            2'b11:   state_d[g] = X2;
            2'b00:   state_d[g] = IDLE;
            2'b10:   state_d[g] = ERR;
            default: state_d[g] = X1;
          endcase
        end
        X2: begin
          case (s_code)
            2'b10:   state_d[g] = X3;
            2'b01:   state_d[g] = X1;
            2'b00:   state_d[g] = ERR;
            default: state_d[g] = X2;
          endcase
        end
        X3: begin
          case (s_code)
            2'b00: begin
              state_d[g]    = IDLE;
              ext_commit[g] = 1'b1;
            end
            2'b11:   state_d[g] = X2;
            2'b01:   state_d[g] = ERR;
            default: state_d[g] = X3;
          endcase
        end
        default: begin
          state_d[g] = (s_code == 2'b00) ? IDLE : ERR;
        end
      endcase
      err_enter[g] = (state_d[g] == ERR) && (state_q[g] != ERR);
    end
  end

  logic [CNT_W-1:0]     no_cars_q, no_cars_d;
  logic                 full_q, full_d, empty_q, empty_d;
  logic                 overflow_q, overflow_d, underflow_q, underflow_d;
  logic [NUM_GATES-1:0] entered_q, exited_q, seq_err_q;
  logic [TW-1:0]        ne, nx;
  logic signed [TW-1:0] t;

  // Entries and exits from all gates net out before clamping, so a same-cycle pair never saturates.
  always_comb begin
    ne = '0;
    nx = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      ne = ne + TW'(ent_commit[g]);
      nx = nx + TW'(ext_commit[g]);
    end
    t           = $signed(TW'(no_cars_q)) + $signed(ne) - $signed(nx);
    overflow_d  = (t > $signed(TW'(CAPACITY)));
    underflow_d = (t < $signed(TW'(0)));
    if (overflow_d) begin
      no_cars_d = CNT_W'(CAPACITY);
    end else if (underflow_d) begin
      no_cars_d = '0;
    end else begin
      no_cars_d = t[CNT_W-1:0];
    end
    full_d  = (no_cars_d == CNT_W'(CAPACITY));
    empty_d = (no_cars_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa_q        <= '0;
      sb_q        <= '0;
      for (int g = 0; g < NUM_GATES; g++) begin
        state_q[g] <= IDLE;
      end
      no_cars_q   <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      entered_q   <= '0;
      exited_q    <= '0;
      seq_err_q   <= '0;
    end else begin
      sa_q        <= a_src;
      sb_q        <= b_src;
      for (int g = 0; g < NUM_GATES; g++) begin
        state_q[g] <= state_d[g];
      end
      no_cars_q   <= no_cars_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      entered_q   <= ent_commit;
      exited_q    <= ext_commit;
      seq_err_q   <= err_enter;
    end
  end

  assign no_cars   = no_cars_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign entered   = entered_q;
  assign exited    = exited_q;
  assign seq_err   = seq_err_q;

endmodule
